// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for one shared combinational ALU.
// Operands are registered into the ALU, results are registered into a
// response that is held until the granted requester takes it.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CODE_W-1:0] req0_code,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CODE_W-1:0] req1_code,
    output logic [WIDTH-1:0]  alu_inp1,
    output logic [WIDTH-1:0]  alu_inp2,
    output logic [CODE_W-1:0] alu_code,
    input  logic [WIDTH-1:0]  alu_outp,
    input  logic [WIDTH-1:0]  alu_mult_high,
    input  logic [WIDTH-1:0]  alu_mult_low,
    input  logic              alu_zflag,
    input  logic              alu_carryflag,
    input  logic              alu_ovfflag,
    input  logic              alu_signflag,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp_outp,
    output logic [WIDTH-1:0]  rsp_mult_high,
    output logic [WIDTH-1:0]  rsp_mult_low,
    output logic [3:0]        rsp_flags,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   grant_id;
    logic   last_grant;

    // Grant at most one requester while idle; a tie goes to whoever did not win last.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    // Accept -> one ALU settle cycle -> hold response until the granted side consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_id      <= 1'b0;
            last_grant    <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 2'b00;
            alu_inp1      <= '0;
            alu_inp2      <= '0;
            alu_code      <= '0;
            rsp_outp      <= '0;
            rsp_mult_high <= '0;
            rsp_mult_low  <= '0;
            rsp_flags     <= 4'b0000;
            ops_done      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid[0] && req_ready[0]) begin
                        alu_inp1   <= req0_a;
                        alu_inp2   <= req0_b;
                        alu_code   <= req0_code;
                        grant_id   <= 1'b0;
                        last_grant <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end else if (req_valid[1] && req_ready[1]) begin
                        alu_inp1   <= req1_a;
                        alu_inp2   <= req1_b;
                        alu_code   <= req1_code;
                        grant_id   <= 1'b1;
                        last_grant <= 1'b1;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_outp      <= alu_outp;
                    rsp_mult_high <= alu_mult_high;
                    rsp_mult_low  <= alu_mult_low;
                    rsp_flags     <= {alu_zflag, alu_carryflag, alu_ovfflag, alu_signflag};
                    rsp_valid     <= grant_id ? 2'b10 : 2'b01;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        if (ops_done != {CNT_W{1'b1}})
                            ops_done <= ops_done + CNT_W'(1);
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: a transaction-level model predicts
// grants, held responses and the completion count; a behavioural ALU
// sits on the DUT's ALU ports. A second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] o;
        logic [31:0] h;
        logic [31:0] l;
        logic [3:0]  f;
    } alu_res_t;

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_code, req1_code;
    logic [31:0] alu_inp1, alu_inp2, alu_outp, alu_mult_high, alu_mult_low;
    logic [3:0]  alu_code;
    logic        alu_zflag, alu_carryflag, alu_ovfflag, alu_signflag;
    logic [31:0] rsp_outp, rsp_mult_high, rsp_mult_low;
    logic [3:0]  rsp_flags;
    logic        busy;
    logic [15:0] ops_done;

    // outputs of the small-counter instance
    logic [1:0]  s_req_ready, s_rsp_valid;
    logic [31:0] s_inp1, s_inp2, s_outp, s_mh, s_ml;
    logic [3:0]  s_code, s_flags;
    logic        s_busy;
    logic [1:0]  s_ops_done;

    int tests = 0;
    int fails = 0;

    // model state
    bit          known = 0;
    bit          in_flight = 0;
    int          age = 0;
    bit          gid = 0;
    bit          last = 1;
    int          done = 0;
    logic [31:0] ea = 0, eb = 0;
    logic [3:0]  ec = 0;
    alu_res_t    er = '0;

    alu_arbiter #(.WIDTH(32), .CODE_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_code(req0_code),
        .req1_a(req1_a), .req1_b(req1_b), .req1_code(req1_code),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_code(alu_code),
        .alu_outp(alu_outp), .alu_mult_high(alu_mult_high), .alu_mult_low(alu_mult_low),
        .alu_zflag(alu_zflag), .alu_carryflag(alu_carryflag),
        .alu_ovfflag(alu_ovfflag), .alu_signflag(alu_signflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_outp(rsp_outp), .rsp_mult_high(rsp_mult_high), .rsp_mult_low(rsp_mult_low),
        .rsp_flags(rsp_flags), .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.WIDTH(32), .CODE_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_code(req0_code),
        .req1_a(req1_a), .req1_b(req1_b), .req1_code(req1_code),
        .alu_inp1(s_inp1), .alu_inp2(s_inp2), .alu_code(s_code),
        .alu_outp(alu_outp), .alu_mult_high(alu_mult_high), .alu_mult_low(alu_mult_low),
        .alu_zflag(alu_zflag), .alu_carryflag(alu_carryflag),
        .alu_ovfflag(alu_ovfflag), .alu_signflag(alu_signflag),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_outp(s_outp), .rsp_mult_high(s_mh), .rsp_mult_low(s_ml),
        .rsp_flags(s_flags), .busy(s_busy), .ops_done(s_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add/sub/and/mul selected by the low opcode bits.
    function automatic alu_res_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] code);
        alu_res_t    r;
        logic [63:0] p;
        logic [32:0] s, d;
        p = {32'd0, a} * {32'd0, b};
        s = {1'b0, a} + {1'b0, b};
        d = {1'b0, a} - {1'b0, b};
        r.h = p[63:32];
        r.l = p[31:0];
        r.f = 4'b0000;
        case (code[1:0])
            2'd0: begin r.o = s[31:0]; r.f[2] = s[32]; r.f[1] = (a[31] == b[31]) && (s[31] != a[31]); end
            2'd1: begin r.o = d[31:0]; r.f[2] = (a < b); r.f[1] = (a[31] != b[31]) && (d[31] != a[31]); end
            2'd2: r.o = a & b;
            default: r.o = p[31:0];
        endcase
        r.f[3] = (r.o == 32'd0);
        r.f[0] = r.o[31];
        return r;
    endfunction

    always_comb begin
        {alu_outp, alu_mult_high, alu_mult_low,
         alu_zflag, alu_carryflag, alu_ovfflag, alu_signflag} = alu_fn(alu_inp1, alu_inp2, alu_code);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which requester the arbiter ought to accept now, one-hot.
    function automatic logic [1:0] exp_ready();
        if (in_flight) return 2'b00;
        if (req_valid == 2'b11) return last ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    task automatic check_outputs();
        logic [1:0] ev;
        int         sat16, sat2;
        ev    = (in_flight && age >= 1) ? (gid ? 2'b10 : 2'b01) : 2'b00;
        sat16 = (done > 65535) ? 65535 : done;
        sat2  = (done > 3) ? 3 : done;
        chk("req_ready", 64'(req_ready), 64'(exp_ready()));
        chk("busy", 64'(busy), 64'(in_flight));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("alu_inp1", 64'(alu_inp1), 64'(ea));
        chk("alu_inp2", 64'(alu_inp2), 64'(eb));
        chk("alu_code", 64'(alu_code), 64'(ec));
        chk("rsp_outp", 64'(rsp_outp), 64'(er.o));
        chk("rsp_mult_high", 64'(rsp_mult_high), 64'(er.h));
        chk("rsp_mult_low", 64'(rsp_mult_low), 64'(er.l));
        chk("rsp_flags", 64'(rsp_flags), 64'(er.f));
        chk("ops_done", 64'(ops_done), 64'(sat16));
        chk("ops_done_sat", 64'(s_ops_done), 64'(sat2));
    endtask

    // Advance the model across the coming rising edge.
    task automatic predict();
        logic [1:0] g;
        g = exp_ready();
        if (rst) begin
            known = 1; in_flight = 0; age = 0; gid = 0; last = 1; done = 0;
            ea = 0; eb = 0; ec = 0; er = '0;
        end else if (!in_flight) begin
            if (g != 2'b00) begin
                gid = g[1];
                last = gid;
                ea = gid ? req1_a : req0_a;
                eb = gid ? req1_b : req0_b;
                ec = gid ? req1_code : req0_code;
                in_flight = 1; age = 0;
            end
        end else if (age == 0) begin
            er = alu_fn(ea, eb, ec);
            age = 1;
        end else if (rsp_ready[gid]) begin
            done++;
            in_flight = 0;
        end
    endtask

    // One cycle: drive inputs, check mid-cycle, then cross the edge.
    task automatic step(input logic r, input logic [1:0] v, input logic [1:0] rr, input bit rnd);
        rst = r; req_valid = v; rsp_ready = rr;
        if (rnd) begin
            req0_a = $urandom; req0_b = $urandom; req0_code = 4'($urandom_range(0, 15));
            req1_a = $urandom; req1_b = $urandom; req1_code = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        if (known) check_outputs();
        predict();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_code = 0; req1_a = 0; req1_b = 0; req1_code = 0;
        step(1, 2'b00, 2'b00, 1);
        step(1, 2'b00, 2'b00, 1);

        // single requester 0 multiply of -2 by 4; operands churn during EXEC
        req0_a = 32'hFFFF_FFFE; req0_b = 32'd4; req0_code = 4'b0011;
        step(0, 2'b01, 2'b00, 0);
        step(0, 2'b00, 2'b00, 1);
        step(0, 2'b00, 2'b01, 1);
        step(0, 2'b00, 2'b00, 1);
        chk("first_op_done", 64'(ops_done), 64'd1);
        chk("first_op_high", 64'(rsp_mult_high), 64'd3);

        // both requesters always valid, responses taken at once: alternating grants
        for (int i = 0; i < 12; i++) step(0, 2'b11, 2'b11, 1);
        chk("rr_ops_done", 64'(ops_done), 64'd5);

        // requester 1 holds its response for 10 cycles; rsp_ready[0] must be ignored
        step(0, 2'b10, 2'b00, 1);
        for (int i = 0; i < 11; i++) step(0, 2'b11, 2'b01, 1);
        step(0, 2'b00, 2'b10, 1);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 63) == 0), 2'($urandom), 2'($urandom), 1);

        // reset while in EXEC aborts, then a tie goes to requester 0
        step(1, 2'b00, 2'b00, 1);
        step(0, 2'b10, 2'b00, 1);
        step(1, 2'b00, 2'b11, 1);
        step(0, 2'b11, 2'b11, 1);
        chk("abort_ops_done", 64'(ops_done), 64'd0);
        chk("tie_after_reset", 64'(alu_inp1), 64'(req0_a));
        step(0, 2'b00, 2'b11, 1);
        step(0, 2'b00, 2'b11, 1);

        // drive the 2-bit counter past saturation
        for (int i = 0; i < 18; i++) step(0, 2'b01, 2'b11, 1);
        chk("sat_ops_done", 64'(s_ops_done), 64'd3);
        chk("wide_ops_done", 64'(ops_done), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
